// File: rtl/ahb_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port AHB RAM.
// M0 is the JTAG debug master, M1 the system master. One transfer is in
// flight at a time: IDLE -> ADDR (one cycle) -> DATA (until HREADY or timeout).
// Every output is driven straight from a flop.
module ahb_ram_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        m0_req,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic              last_r, last_s;        // last granted master, 1'b1 = M1
   logic              write_r, write_s;
   logic [31:0]       addr_r, addr_s;
   logic [31:0]       wdata_r, wdata_s;
   logic [WAIT_W-1:0] wait_r, wait_s, wait_inc_s;
   logic [1:0]        htrans_r, htrans_s;
   logic [31:0]       hwdata_r, hwdata_s;
   logic [1:0]        gnt_r, gnt_s;
   logic [1:0]        done_r, done_s;
   logic [1:0]        err_r, err_s;
   logic [31:0]       rdata0_r, rdata0_s;
   logic [31:0]       rdata1_r, rdata1_s;
   logic [1:0]        elig_s;
   logic [1:0]        owner_s;
   logic              pick_s;

   // Next-state, arbitration and next-output decode for the transfer FSM.
   always_comb begin
      state_s    = state_r;
      last_s     = last_r;
      write_s    = write_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      wait_s     = wait_r;
      htrans_s   = 2'b00;
      hwdata_s   = 32'h0000_0000;
      gnt_s      = 2'b00;
      done_s     = 2'b00;
      err_s      = 2'b00;
      rdata0_s   = rdata0_r;
      rdata1_s   = rdata1_r;
      wait_inc_s = wait_r + WAIT_W'(1);
      owner_s    = last_r ? 2'b10 : 2'b01;

      // a master being told "done" this cycle sits out this edge
      elig_s = {m1_req & ~done_r[1], m0_req & ~done_r[0]};
      if (elig_s == 2'b11) begin
         pick_s = ~last_r;
      end else if (elig_s[1]) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end

      case (state_r)
         ST_IDLE: begin
            if (elig_s != 2'b00) begin
               state_s  = ST_ADDR;
               last_s   = pick_s;
               write_s  = pick_s ? m1_write : m0_write;
               addr_s   = pick_s ? m1_addr  : m0_addr;
               wdata_s  = pick_s ? m1_wdata : m0_wdata;
               wait_s   = {WAIT_W{1'b0}};
               htrans_s = 2'b10;
               gnt_s    = pick_s ? 2'b10 : 2'b01;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            state_s  = ST_DATA;
            hwdata_s = write_r ? wdata_r : 32'h0000_0000;
            gnt_s    = owner_s;
         end
         ST_DATA: begin
            if (HREADY) begin
               state_s = ST_IDLE;
               done_s  = owner_s;
               if (write_r) begin
                  rdata0_s = rdata0_r;
               end else if (last_r) begin
                  rdata1_s = HRDATA;
               end else begin
                  rdata0_s = HRDATA;
               end
            end else if (wait_inc_s == WAIT_W'(TIMEOUT)) begin
               // slave stalled too long: abort and report the error
               state_s = ST_IDLE;
               done_s  = owner_s;
               err_s   = owner_s;
            end else begin
               wait_s   = wait_inc_s;
               hwdata_s = write_r ? wdata_r : 32'h0000_0000;
               gnt_s    = owner_s;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched transfer operands, wait counter and registered outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_r   <= 1'b1;
         write_r  <= 1'b0;
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
         wait_r   <= {WAIT_W{1'b0}};
         htrans_r <= 2'b00;
         hwdata_r <= 32'h0000_0000;
         gnt_r    <= 2'b00;
         done_r   <= 2'b00;
         err_r    <= 2'b00;
         rdata0_r <= 32'h0000_0000;
         rdata1_r <= 32'h0000_0000;
      end else begin
         last_r   <= last_s;
         write_r  <= write_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         wait_r   <= wait_s;
         htrans_r <= htrans_s;
         hwdata_r <= hwdata_s;
         gnt_r    <= gnt_s;
         done_r   <= done_s;
         err_r    <= err_s;
         rdata0_r <= rdata0_s;
         rdata1_r <= rdata1_s;
      end
   end

   assign HTRANS   = htrans_r;
   assign HADDR    = addr_r;
   assign HWRITE   = write_r;
   assign HWDATA   = hwdata_r;
   assign m0_gnt   = gnt_r[0];
   assign m1_gnt   = gnt_r[1];
   assign m0_done  = done_r[0];
   assign m1_done  = done_r[1];
   assign m0_err   = err_r[0];
   assign m1_err   = err_r[1];
   assign m0_rdata = rdata0_r;
   assign m1_rdata = rdata1_r;

endmodule
